// File: rtl/load_store_unit_if.sv
// lsu_if: core request/response handshake plus word-wide data memory port of the load/store unit.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_wr_en;
    logic [31:0] mem_rd;
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_wr_en
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_wr_en
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word load-store initiator; sub-word stores use read-modify-write.
// Define LSU_ERR_CHECK_EN to report misaligned, out-of-range and illegal-funct3 requests as errors.
module load_store_unit #(
    parameter int MEM_WORDS = 1024,
    parameter int WIDX_W    = 10
) (
    input logic  clk,
    input logic  reset,
    lsu_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP} state_t;
    state_t      state;
    logic [1:0]  sz_r, off_r, sz, off;
    logic        uns_r, bad_f3, err;
    logic [31:0] wdata_r, rd_sh, ld_data, mask, merged;
    logic [4:0]  sh;
    always_comb begin
        bad_f3 = bus.req_we ? bus.req_funct3 >= 3'd3
                            : (bus.req_funct3[1:0] == 2'd3 || bus.req_funct3 == 3'd6);
        sz = bad_f3 ? 2'd2 : bus.req_funct3[1:0];
`ifdef LSU_ERR_CHECK_EN
        off = bus.req_addr[1:0];
        err = bad_f3 || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0) ||
              bus.req_addr >= 32'(4 * MEM_WORDS);
`else
        // Misaligned accesses snap down to natural alignment; high address bits wrap.
        off = sz == 2'd2 ? 2'd0 : {bus.req_addr[1], bus.req_addr[0] & (sz == 2'd0)};
        err = 1'b0;
`endif
        sh = {off_r, 3'b000};
        rd_sh = bus.mem_rd >> sh;
        ld_data = sz_r == 2'd0 ? {{24{~uns_r & rd_sh[7]}}, rd_sh[7:0]} :
                  sz_r == 2'd1 ? {{16{~uns_r & rd_sh[15]}}, rd_sh[15:0]} : bus.mem_rd;
        mask = (sz_r == 2'd0 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        merged = (bus.mem_rd & ~mask) | ((wdata_r << sh) & mask);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.mem_wr_en  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wd     <= '0;
            sz_r           <= '0;
            off_r          <= '0;
            uns_r          <= 1'b0;
            wdata_r        <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    bus.req_ready <= 1'b0;
                    sz_r          <= sz;
                    off_r         <= off;
                    uns_r         <= bus.req_funct3[2];
                    wdata_r       <= bus.req_wdata;
                    if (err) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                    end else begin
                        bus.mem_addr <= {{(32-WIDX_W){1'b0}}, bus.req_addr[WIDX_W+1:2]};
                        if (!bus.req_we) state <= LOAD;
                        else if (sz == 2'd2) begin
                            state         <= STORE_W;
                            bus.mem_wd    <= bus.req_wdata;
                            bus.mem_wr_en <= 1'b1;
                        end else state <= RMW_RD;
                    end
                end
                LOAD: begin
                    bus.resp_rdata <= ld_data;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RMW_RD: begin
                    bus.mem_wd    <= merged;
                    bus.mem_wr_en <= 1'b1;
                    state         <= RMW_WR;
                end
                STORE_W, RMW_WR: begin
                    bus.mem_wr_en  <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_rdata <= '0;
                    bus.resp_err   <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store sequence with a scoreboard of expected responses and memory writes.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    lsu_if bus();
    load_store_unit #(.MEM_WORDS(1024), .WIDX_W(10)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    logic [31:0] mem [1024];
    assign bus.mem_rd = mem[bus.mem_addr[9:0]];
    always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr[9:0]] <= bus.mem_wd;
    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          wcyc;
        logic [31:0] wd;
    } exp_t;
    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] e_rd, input logic e_err, input int e_lat,
                        input int e_wcyc, input logic [31:0] e_wd, input bit hold);
        int lat;
        int wcyc;
        int nw;
        logic [31:0] wdv;
        logic [31:0] held;
        exp_t e;
        q.push_back('{e_rd, e_err, e_lat, e_wcyc, e_wd});
        @(negedge clk);
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.resp_ready = !hold;
        bus.req_we = we;
        bus.req_funct3 = f3;
        bus.req_addr = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        wcyc = -1;
        nw = 0;
        wdv = '0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.mem_wr_en) begin
                nw++;
                wcyc = lat;
                wdv = bus.mem_wd;
            end
        end while (!bus.resp_valid && lat < 20);
        e = q.pop_front();
        chk({tag, " latency"}, 32'(lat), 32'(e.lat));
        chk({tag, " rdata"}, bus.resp_rdata, e.rd);
        chk({tag, " err"}, 32'(bus.resp_err), 32'(e.err));
        chk({tag, " writes"}, 32'(nw), e.wcyc >= 0 ? 32'd1 : 32'd0);
        if (e.wcyc >= 0) begin
            chk({tag, " write cycle"}, 32'(wcyc), 32'(e.wcyc));
            chk({tag, " mem_wd"}, wdv, e.wd);
        end
        if (hold) begin
            held = bus.resp_rdata;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk({tag, " hold valid"}, 32'(bus.resp_valid), 32'd1);
                chk({tag, " hold rdata"}, bus.resp_rdata, held);
                chk({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
                chk({tag, " hold wr_en"}, 32'(bus.mem_wr_en), 32'd0);
            end
            bus.resp_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, " consumed"}, 32'(bus.resp_valid), 32'd0);
    endtask
    logic [31:0] word0;
    initial begin
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst mem_wd", bus.mem_wd, 32'd0);
        reset = 1'b0;
        xact("pre w0", 1, 3'd2, 32'h00, 32'h0000_0055, 32'h0, 0, 2, 1, 32'h0000_0055, 0);
        xact("pre w1", 1, 3'd2, 32'h04, 32'h0000_0001, 32'h0, 0, 2, 1, 32'h0000_0001, 0);
        xact("pre w2", 1, 3'd2, 32'h08, 32'h0000_0002, 32'h0, 0, 2, 1, 32'h0000_0002, 0);
        xact("pre w3", 1, 3'd2, 32'h0C, 32'h0000_0005, 32'h0, 0, 2, 1, 32'h0000_0005, 0);
        xact("pre w5", 1, 3'd2, 32'h14, 32'h8000_F0A5, 32'h0, 0, 2, 1, 32'h8000_F0A5, 0);
        xact("lw 0", 0, 3'd2, 32'h00, 32'h0, 32'h0000_0055, 0, 2, -1, 32'h0, 0);
        xact("lb 14", 0, 3'd0, 32'h14, 32'h0, 32'hFFFF_FFA5, 0, 2, -1, 32'h0, 0);
        xact("lbu 14", 0, 3'd4, 32'h14, 32'h0, 32'h0000_00A5, 0, 2, -1, 32'h0, 0);
        xact("lh 16", 0, 3'd1, 32'h16, 32'h0, 32'hFFFF_8000, 0, 2, -1, 32'h0, 0);
        xact("lhu 16", 0, 3'd5, 32'h16, 32'h0, 32'h0000_8000, 0, 2, -1, 32'h0, 0);
        xact("lbu 17", 0, 3'd4, 32'h17, 32'h0, 32'h0000_0080, 0, 2, -1, 32'h0, 0);
        xact("sb 05", 1, 3'd0, 32'h05, 32'h1234_56EE, 32'h0, 0, 3, 2, 32'h0000_EE01, 0);
        xact("lw 4", 0, 3'd2, 32'h04, 32'h0, 32'h0000_EE01, 0, 2, -1, 32'h0, 0);
        xact("sh 0a", 1, 3'd1, 32'h0A, 32'h0000_BEEF, 32'h0, 0, 3, 2, 32'hBEEF_0002, 0);
        xact("lw 8", 0, 3'd2, 32'h08, 32'h0, 32'hBEEF_0002, 0, 2, -1, 32'h0, 0);
        xact("sw 0c", 1, 3'd2, 32'h0C, 32'hDEAD_BEEF, 32'h0, 0, 2, 1, 32'hDEAD_BEEF, 0);
        xact("lw c hold", 0, 3'd2, 32'h0C, 32'h0, 32'hDEAD_BEEF, 0, 2, -1, 32'h0, 1);
`ifdef LSU_ERR_CHECK_EN
        xact("err lw 2", 0, 3'd2, 32'h02, 32'h0, 32'h0, 1, 1, -1, 32'h0, 0);
        xact("err sw 1000", 1, 3'd2, 32'h1000, 32'h0000_0077, 32'h0, 1, 1, -1, 32'h0, 0);
        xact("err sh 1", 1, 3'd1, 32'h01, 32'h0000_1111, 32'h0, 1, 1, -1, 32'h0, 0);
        xact("err ld f3=3", 0, 3'd3, 32'h04, 32'h0, 32'h0, 1, 1, -1, 32'h0, 0);
        xact("err sw f3=4", 1, 3'd4, 32'h04, 32'h0, 32'h0, 1, 1, -1, 32'h0, 0);
        word0 = 32'h0000_0055;
`else
        xact("lw 2 aligned", 0, 3'd2, 32'h02, 32'h0, 32'h0000_0055, 0, 2, -1, 32'h0, 0);
        xact("lh 17 aligned", 0, 3'd1, 32'h17, 32'h0, 32'hFFFF_8000, 0, 2, -1, 32'h0, 0);
        xact("ld f3=3 as lw", 0, 3'd3, 32'h04, 32'h0, 32'h0000_EE01, 0, 2, -1, 32'h0, 0);
        xact("sw 1000 wrap", 1, 3'd2, 32'h1000, 32'h0000_0077, 32'h0, 0, 2, 1, 32'h0000_0077, 0);
        word0 = 32'h0000_0077;
`endif
        xact("lw 0 again", 0, 3'd2, 32'h00, 32'h0, word0, 0, 2, -1, 32'h0, 0);
        @(negedge clk);
        bus.req_we = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_addr = 32'h00;
        bus.req_wdata = 32'h0000_00AA;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rmw rst wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("rmw rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rmw rst req_ready", 32'(bus.req_ready), 32'd1);
        xact("lw 0 post rst", 0, 3'd2, 32'h00, 32'h0, word0, 0, 2, -1, 32'h0, 0);
        chk("scoreboard empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
